megaram_mapper: RTL and testbench

MEGARAM_MAPPER -- requirements
Module: megaram_mapper

---
 rtl/megaram_pkg.sv | 40 ++++
 rtl/megaram_bank_decode.sv | 49 ++++
 rtl/megaram_mapper.sv | 149 ++++++++++++++
 tb/tb_megaram_mapper.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/megaram_pkg.sv
// megaram_pkg: mapper mode encodings, I/O port number and window constants
// shared by the MegaRAM mapper and its write-address decoder.
package megaram_pkg;

  // Mapper personalities selected by the mode input
  localparam logic [2:0] MODE_KONAMI  = 3'b000;
  localparam logic [2:0] MODE_KSCC    = 3'b001;
  localparam logic [2:0] MODE_ASCII16 = 3'b010;
  localparam logic [2:0] MODE_ASCII8  = 3'b011;
  localparam logic [2:0] MODE_GENERIC = 3'b100;

  // I/O port that switches the cartridge between bank-select and RAM-write
  localparam logic [7:0] PORT_RAM_CTRL = 8'h8E;

  // Cartridge windows: four 8K pages starting at 4000h
  localparam logic [15:0] WIN0_BASE = 16'h4000;
  localparam logic [15:0] WIN1_BASE = 16'h6000;
  localparam logic [15:0] WIN3_BASE = 16'hA000;
  localparam logic [15:0] WIN_SPAN  = 16'h2000;

  // SCC register page and the sub-range that needs the bus held
  localparam logic [15:0] SCC_REG_BASE = 16'h9000;
  localparam logic [15:0] SCC_WAV_BASE = 16'h9800;

  // Undefined encodings fall back to plain Konami
  function automatic logic [2:0] norm_mode(input logic [2:0] m);
    return (m > MODE_GENERIC) ? MODE_KONAMI : m;
  endfunction

  // 8K window number 0..3 for an address inside the cartridge range
  function automatic logic [1:0] win_idx(input logic [15:0] a);
    return 2'((a - WIN0_BASE) >> 13);
  endfunction

  // True for 4000h..BFFFh
  function automatic logic in_cart(input logic [15:0] a);
    return (a >= WIN0_BASE) && (a < (WIN3_BASE + WIN_SPAN));
  endfunction

endpackage

// File: rtl/megaram_bank_decode.sv
// megaram_bank_decode: decides whether a cartridge write address selects a
// bank register in the current mapper mode, and which one.
module megaram_bank_decode
  import megaram_pkg::*;
(
  input  logic [2:0]  mode,
  input  logic [15:0] addr,
  output logic        hit,
  output logic [1:0]  idx
);

  logic cart;

  assign cart = in_cart(addr);

  // Per-mode bank-select address decode
  always_comb begin
    hit = 1'b0;
    idx = win_idx(addr);
    case (mode)
      MODE_KSCC: begin
        // 5000-57FF, 7000-77FF, 9000-97FF, B000-B7FF
        hit = cart && (addr[12:11] == 2'b10);
      end
      MODE_ASCII16: begin
        if (addr[15:11] == WIN1_BASE[15:11]) begin
          hit = 1'b1;
          idx = 2'd0;
        end else if (addr[15:11] == (WIN1_BASE[15:11] | 5'b00010)) begin
          hit = 1'b1;
          idx = 2'd1;
        end
      end
      MODE_ASCII8: begin
        // 2K slots at 6000h, 6800h, 7000h, 7800h
        hit = (addr[15:13] == WIN1_BASE[15:13]);
        idx = addr[12:11];
      end
      MODE_GENERIC: begin
        hit = cart;
      end
      default: begin
        // Konami: page 0 is fixed, pages 1..3 selectable
        hit = cart && (addr >= WIN1_BASE);
      end
    endcase
  end

endmodule

// File: rtl/megaram_mapper.sv
// megaram_mapper: MSX MegaRAM / MegaROM bank mapper translating Z80 cartridge
// accesses into physical memory addresses, with SCC register support.
module megaram_mapper
  import megaram_pkg::*;
#(
  parameter int              ADDR_W    = 23,
  parameter logic [ADDR_W-1:0] BASE    = 23'h420000,
  parameter int              BANK_W    = 8,
  parameter int              SIZE_LOG2 = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       addr,
  input  logic [7:0]        cdin,
  input  logic              sltsl_n,
  input  logic              merq_n,
  input  logic              iorq_n,
  input  logic              m1_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [2:0]        mode,
  input  logic              scc_enable,
  output logic              cart_ena,
  output logic              ram_ena,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              busreq,
  output logic              scc_sel,
  output logic              bank_wr
);

  // Bank numbers wrap at the image size
  localparam logic [ADDR_W-1:0] MASK8  = ADDR_W'((64'd1 << (SIZE_LOG2 - 13)) - 64'd1);
  localparam logic [ADDR_W-1:0] MASK16 = ADDR_W'((64'd1 << (SIZE_LOG2 - 14)) - 64'd1);

  logic [2:0]              mode_n;
  logic [2:0]              mode_prev_reg;
  logic                    mode_chg;
  logic                    wr_hist_reg, wr_arm_reg, rd_hist_reg, rd_arm_reg;
  logic                    wr_commit, rd_commit;
  logic                    io_hit;
  logic                    dec_hit;
  logic [1:0]              dec_idx;
  logic                    bank_load;
  logic                    ram_ena_reg, scc_active_reg, bank_wr_reg;
  logic [3:0][BANK_W-1:0]  bank_val;
  logic [BANK_W-1:0]       sel_bank;
  logic [ADDR_W-1:0]       bank_ext;

  assign mode_n   = norm_mode(mode);
  assign mode_chg = (mode != mode_prev_reg);
  assign cart_ena = in_cart(addr) && !sltsl_n && !merq_n && iorq_n;
  assign io_hit   = !iorq_n && m1_n && (addr[7:0] == PORT_RAM_CTRL);

  // A strobe commits on its falling edge only; the arm flag keeps a strobe
  // that was already low when reset released from committing.
  assign wr_commit = !wr_n && wr_hist_reg && wr_arm_reg;
  assign rd_commit = !rd_n && rd_hist_reg && rd_arm_reg;

  megaram_bank_decode u_decode (
    .mode (mode_n),
    .addr (addr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  // Mode changes discard any commit in the same clock
  assign bank_load = wr_commit && cart_ena && dec_hit && !ram_ena_reg && !mode_chg;

  // Strobe history, arm flags and previous mode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_hist_reg   <= 1'b1;
      rd_hist_reg   <= 1'b1;
      wr_arm_reg    <= 1'b0;
      rd_arm_reg    <= 1'b0;
      mode_prev_reg <= MODE_KONAMI;
    end else begin
      wr_hist_reg   <= wr_n;
      rd_hist_reg   <= rd_n;
      wr_arm_reg    <= wr_arm_reg | wr_n;
      rd_arm_reg    <= rd_arm_reg | rd_n;
      mode_prev_reg <= mode;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bank
      logic [BANK_W-1:0] bank_reg;
      // Bank register gi: reset value is its own index, reloaded on mode change
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          bank_reg <= BANK_W'(gi);
        end else if (mode_chg) begin
          bank_reg <= BANK_W'(gi);
        end else if (bank_load && (dec_idx == 2'(gi))) begin
          bank_reg <= BANK_W'(cdin);
        end
      end
      assign bank_val[gi] = bank_reg;
    end
  endgenerate

  // RAM-write enable via port 8Eh, SCC activation and the bank update strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_ena_reg    <= 1'b0;
      scc_active_reg <= 1'b0;
      bank_wr_reg    <= 1'b0;
    end else begin
      bank_wr_reg <= bank_load;
      if (mode_chg) begin
        scc_active_reg <= 1'b0;
      end else begin
        if (io_hit && rd_commit) begin
          ram_ena_reg <= 1'b1;
        end else if (io_hit && wr_commit) begin
          ram_ena_reg <= 1'b0;
        end
        if (wr_commit && cart_ena && (mode == MODE_KSCC) && scc_enable &&
            (addr[15:11] == SCC_REG_BASE[15:11])) begin
          scc_active_reg <= (cdin[5:0] == 6'h3F);
        end
      end
    end
  end

  // Physical address: 16K pages in ASCII16, 8K pages otherwise
  always_comb begin
    sel_bank = bank_val[win_idx(addr)];
    if (mode_n == MODE_ASCII16) begin
      sel_bank = bank_val[{1'b0, addr[15]}];
    end
    bank_ext = ADDR_W'(sel_bank);
    if (mode_n == MODE_ASCII16) begin
      mem_addr = BASE + ((bank_ext & MASK16) << 14) + ADDR_W'(addr[13:0]);
    end else begin
      mem_addr = BASE + ((bank_ext & MASK8) << 13) + ADDR_W'(addr[12:0]);
    end
  end

  assign ram_ena = ram_ena_reg;
  assign bank_wr = bank_wr_reg;
  assign scc_sel = (mode == MODE_KSCC) && scc_enable && cart_ena &&
                   (addr[15:12] == SCC_REG_BASE[15:12]);
  assign busreq  = scc_active_reg && scc_enable && !rd_n && cart_ena &&
                   (addr[15:11] == SCC_WAV_BASE[15:11]);

endmodule

// File: tb/tb_megaram_mapper.sv
// tb_megaram_mapper: directed stimulus with a scoreboard; expected read
// responses and bank_wr pulses are queued by the stimulus and checked by a
// separate monitor.
module tb_megaram_mapper;

  typedef struct {
    string       name;
    logic [22:0] maddr;
    logic        chk_addr;
    logic        cart;
    logic        ram;
    logic        breq;
    logic        scc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  cdin = 8'h00;
  logic        sltsl_n = 1'b1, merq_n = 1'b1, iorq_n = 1'b1, m1_n = 1'b1;
  logic        rd_n = 1'b1, wr_n = 1'b1;
  logic [2:0]  mode = 3'b000;
  logic        scc_enable = 1'b0;
  logic        cart_ena, ram_ena, busreq, scc_sel, bank_wr;
  logic [22:0] mem_addr;

  logic        chk_stb = 1'b0;
  exp_t        exp_q[$];
  string       pulse_q[$];
  int          errors = 0;
  int          checks = 0;
  exp_t        cur;
  string       pname;

  megaram_mapper dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .cdin       (cdin),
    .sltsl_n    (sltsl_n),
    .merq_n     (merq_n),
    .iorq_n     (iorq_n),
    .m1_n       (m1_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .mode       (mode),
    .scc_enable (scc_enable),
    .cart_ena   (cart_ena),
    .ram_ena    (ram_ena),
    .mem_addr   (mem_addr),
    .busreq     (busreq),
    .scc_sel    (scc_sel),
    .bank_wr    (bank_wr)
  );

  always #5 clk = ~clk;

  // Monitor: compares bank_wr pulses and sampled read responses
  always @(negedge clk) begin
    if (bank_wr !== 1'b0) begin
      checks++;
      if (pulse_q.size() == 0) begin
        errors++;
        $display("FAIL bank_wr: got pulse (%b), required none", bank_wr);
      end else begin
        pname = pulse_q.pop_front();
        $display("bank_wr %s: pulse ok", pname);
      end
    end
    if (chk_stb) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL monitor: sample with empty expectation queue");
      end else begin
        cur = exp_q.pop_front();
        if ((cart_ena === cur.cart) && (ram_ena === cur.ram) &&
            (busreq === cur.breq) && (scc_sel === cur.scc) &&
            (!cur.chk_addr || (mem_addr === cur.maddr))) begin
          $display("read %s: mem_addr=%h cart=%b ram=%b busreq=%b scc=%b ok",
                   cur.name, mem_addr, cart_ena, ram_ena, busreq, scc_sel);
        end else begin
          errors++;
          $display("FAIL %s: got mem_addr=%h cart=%b ram=%b busreq=%b scc=%b, required mem_addr=%h(chk=%b) cart=%b ram=%b busreq=%b scc=%b",
                   cur.name, mem_addr, cart_ena, ram_ena, busreq, scc_sel,
                   cur.maddr, cur.chk_addr, cur.cart, cur.ram, cur.breq, cur.scc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sltsl_n = 1'b1; merq_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1;
    rd_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic mem_write(input string nm, input logic [15:0] a,
                           input logic [7:0] d, input bit pulse, input int hold);
    if (pulse) pulse_q.push_back(nm);
    addr = a; cdin = d; sltsl_n = 1'b0; merq_n = 1'b0; wr_n = 1'b0;
    tick(hold);
    idle();
    tick(1);
  endtask

  task automatic mem_read(input string nm, input logic [15:0] a, input bit chk,
                          input logic [22:0] ea, input bit ec, input bit er,
                          input bit eb, input bit es);
    exp_t e;
    e.name = nm; e.maddr = ea; e.chk_addr = chk;
    e.cart = ec; e.ram = er; e.breq = eb; e.scc = es;
    exp_q.push_back(e);
    addr = a; sltsl_n = 1'b0; merq_n = 1'b0; rd_n = 1'b0; chk_stb = 1'b1;
    tick(1);
    chk_stb = 1'b0;
    idle();
    tick(1);
  endtask

  task automatic io_access(input bit is_read);
    addr = 16'h008E; iorq_n = 1'b0; m1_n = 1'b1;
    if (is_read) rd_n = 1'b0; else wr_n = 1'b0;
    tick(1);
    idle();
    tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    tick(3);
    reset = 1'b0;
    tick(2);

    // Reset state, Konami
    mem_read("rst_6000", 16'h6000, 1, 23'h422000, 1, 0, 0, 0);
    mem_read("rst_A000", 16'hA000, 1, 23'h426000, 1, 0, 0, 0);
    mem_read("out_C000", 16'hC000, 0, 23'h000000, 0, 0, 0, 0);
    mem_read("out_3FFF", 16'h3FFF, 0, 23'h000000, 0, 0, 0, 0);

    // Konami bank selects
    mem_write("kon_8000", 16'h8000, 8'h05, 1, 1);
    mem_read("kon_8123", 16'h8123, 1, 23'h42A123, 1, 0, 0, 0);
    mem_write("kon_4000", 16'h4000, 8'h44, 0, 1);
    mem_read("kon_fix0", 16'h4000, 1, 23'h420000, 1, 0, 0, 0);
    mem_write("kon_A000", 16'hA000, 8'h11, 1, 1);
    mem_read("kon_A000", 16'hA000, 1, 23'h442000, 1, 0, 0, 0);

    // Mode change reloads banks on the next clock
    mode = 3'b011;
    tick(1);
    mem_read("chg_8000", 16'h8000, 1, 23'h424000, 1, 0, 0, 0);
    mem_read("chg_A000", 16'hA000, 1, 23'h426000, 1, 0, 0, 0);

    // ASCII8: held wr_n commits once
    mem_write("a8_hold", 16'h6000, 8'h5A, 1, 10);
    mem_read("a8_4000", 16'h4000, 1, 23'h4D4000, 1, 0, 0, 0);
    mem_write("a8_7800", 16'h7800, 8'h07, 1, 1);
    mem_read("a8_A010", 16'hA010, 1, 23'h42E010, 1, 0, 0, 0);

    // Reset in the middle of a write
    addr = 16'h6000; cdin = 8'h22; sltsl_n = 1'b0; merq_n = 1'b0; wr_n = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(3);
    idle();
    tick(1);
    mem_read("rst_nocommit", 16'h4000, 1, 23'h420000, 1, 0, 0, 0);
    mem_write("a8_after_rst", 16'h6000, 8'h22, 1, 1);
    mem_read("a8_rst_4000", 16'h4000, 1, 23'h464000, 1, 0, 0, 0);

    // ASCII16 with wrap
    mode = 3'b010;
    tick(2);
    mem_write("a16_7000", 16'h7000, 8'h47, 1, 1);
    mem_read("a16_8000", 16'h8000, 1, 23'h43C000, 1, 0, 0, 0);
    mem_read("a16_BFFF", 16'hBFFF, 1, 23'h43FFFF, 1, 0, 0, 0);
    mem_write("a16_6000", 16'h6000, 8'h03, 1, 1);
    mem_read("a16_4123", 16'h4123, 1, 23'h42C123, 1, 0, 0, 0);
    mem_write("a16_6800", 16'h6800, 8'h09, 0, 1);
    mem_read("a16_4000", 16'h4000, 1, 23'h42C000, 1, 0, 0, 0);

    // Generic with RAM-write enable
    mode = 3'b100;
    tick(2);
    io_access(1'b1);
    mem_write("gen_ram", 16'h4000, 8'h33, 0, 1);
    mem_read("gen_ram_4000", 16'h4000, 1, 23'h420000, 1, 1, 0, 0);
    io_access(1'b0);
    mem_read("gen_rom_4010", 16'h4010, 1, 23'h420010, 1, 0, 0, 0);
    mem_write("gen_4000", 16'h4000, 8'h33, 1, 1);
    mem_read("gen_4000", 16'h4000, 1, 23'h486000, 1, 0, 0, 0);
    mem_write("gen_A000", 16'hA000, 8'h81, 1, 1);
    mem_read("gen_wrap", 16'hA000, 1, 23'h422000, 1, 0, 0, 0);

    // KonamiSCC
    mode = 3'b001;
    scc_enable = 1'b1;
    tick(2);
    mem_write("scc_on", 16'h9000, 8'h3F, 1, 1);
    mem_read("scc_9800", 16'h9800, 1, 23'h49F800, 1, 0, 1, 1);
    mem_read("scc_8000", 16'h8000, 1, 23'h49E000, 1, 0, 0, 0);
    mem_write("scc_off", 16'h9000, 8'h00, 1, 1);
    mem_read("scc_9800_off", 16'h9800, 1, 23'h421800, 1, 0, 0, 1);
    mem_write("scc_5000", 16'h5000, 8'h07, 1, 1);
    mem_read("scc_4000", 16'h4000, 1, 23'h42E000, 1, 0, 0, 0);
    mem_write("scc_5800", 16'h5800, 8'h0C, 0, 1);
    mem_read("scc_4000b", 16'h4000, 1, 23'h42E000, 1, 0, 0, 0);

    tick(3);
    checks++;
    if (pulse_q.size() != 0) begin
      errors++;
      $display("FAIL bank_wr_missing: %0d expected pulses never seen, required 0",
               pulse_q.size());
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL read_missing: %0d expected samples left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
